// File: rtl/tone_oscillator.sv
// Square-wave tone generator with continuous and one-shot note modes.
// Optional macro TONE_OSC_DUTY_EN adds a latched duty input that replaces 50% toggling.
module tone_oscillator #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DUR_W = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  input  logic [DUR_W-1:0] duration,
`ifdef TONE_OSC_DUTY_EN
  input  logic [CNT_W-1:0] duty,
`endif
  output logic             wave_out,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic               mode_q, mode_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic               tick_q, tick_d;
  logic               wave_q, wave_d;
  logic               done_q, done_d;
`ifdef TONE_OSC_DUTY_EN
  logic [CNT_W-1:0]   duty_q, duty_d;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      tick_q  <= 1'b0;
      wave_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TONE_OSC_DUTY_EN
      duty_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      wave_q  <= wave_d;
      done_q  <= done_d;
`ifdef TONE_OSC_DUTY_EN
      duty_q  <= duty_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    wave_d  = wave_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
`ifdef TONE_OSC_DUTY_EN
    duty_d  = duty_q;
`endif

    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      wave_d  = 1'b0;
    end else if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      per_d   = period;
      mode_d  = mode;
      rem_d   = duration;
      wave_d  = 1'b0;
`ifdef TONE_OSC_DUTY_EN
      duty_d  = duty;
`endif
    end else if (state_q == RUN) begin
      // A one-shot that enters RUN with nothing remaining can only be a zero-length note.
      if (mode_q && (rem_q == '0)) begin
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        wave_d  = 1'b0;
      end else if (en) begin
        if (cnt_q < per_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d  = '0;
          tick_d = 1'b1;
`ifndef TONE_OSC_DUTY_EN
          wave_d = ~wave_q;
`endif
          if (mode_q) rem_d = rem_q - DUR_W'(1);
        end
`ifdef TONE_OSC_DUTY_EN
        wave_d = (cnt_d < duty_q);
`endif
        if (mode_q && tick_d && (rem_q == DUR_W'(1))) begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          wave_d  = 1'b0;
        end
      end
    end
  end

  assign wave_out = wave_q;
  assign tick     = tick_q;
  assign done     = done_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_tone_oscillator.sv
// Directed plus randomized bench for tone_oscillator against an integer behavioural model.
module tb_tone_oscillator;

  logic        clk = 1'b0;
  logic        nRst, en, start, stop, mode;
  logic [7:0]  period;
  logic [15:0] duration;
  logic        wave_out, tick, busy, done;
`ifdef TONE_OSC_DUTY_EN
  logic [7:0]  duty;
`endif

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int m_run, m_cnt, m_per, m_mode, m_rem, m_wave, m_tick, m_done, m_duty;
  // observation counters
  int cyc, n_tick, n_done, n_busy, last_tick, max_gap;

  tone_oscillator #(.CNT_W(8), .DUR_W(16)) dut (
    .clk(clk), .nRst(nRst), .en(en), .start(start), .stop(stop), .mode(mode),
    .period(period), .duration(duration),
`ifdef TONE_OSC_DUTY_EN
    .duty(duty),
`endif
    .wave_out(wave_out), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_per = 0; m_mode = 0; m_rem = 0;
    m_wave = 0; m_tick = 0; m_done = 0; m_duty = 0;
  endtask

  task automatic model_step();
    m_tick = 0;
    m_done = 0;
    if (!nRst) begin
      model_reset();
    end else if (stop) begin
      m_run = 0; m_cnt = 0; m_wave = 0;
    end else if (start) begin
      m_run = 1; m_cnt = 0; m_wave = 0;
      m_per = period; m_mode = mode; m_rem = duration;
`ifdef TONE_OSC_DUTY_EN
      m_duty = duty;
`endif
    end else if (m_run != 0) begin
      if (m_mode != 0 && m_rem == 0) begin
        m_done = 1; m_run = 0; m_cnt = 0; m_wave = 0;
      end else if (en) begin
        if (m_cnt < m_per) m_cnt++;
        else begin
          m_cnt = 0; m_tick = 1;
          m_wave = 1 - m_wave;
          if (m_mode != 0) m_rem--;
        end
`ifdef TONE_OSC_DUTY_EN
        m_wave = (m_cnt < m_duty) ? 1 : 0;
`endif
        if (m_mode != 0 && m_tick != 0 && m_rem == 0) begin
          m_done = 1; m_run = 0; m_cnt = 0; m_wave = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".wave"}, 32'(wave_out), 32'(m_wave));
    check({where, ".tick"}, 32'(tick),     32'(m_tick));
    check({where, ".busy"}, 32'(busy),     32'(m_run));
    check({where, ".done"}, 32'(done),     32'(m_done));
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    if (tick === 1'b1) begin
      n_tick++;
      if (last_tick >= 0 && (cyc - last_tick) > max_gap) max_gap = cyc - last_tick;
      last_tick = cyc;
    end
    if (done === 1'b1) n_done++;
    if (busy === 1'b1) n_busy++;
    compare_all(where);
  endtask

  task automatic clear_obs();
    n_tick = 0; n_done = 0; n_busy = 0; last_tick = -1; max_gap = 0;
  endtask

  task automatic begin_note(input logic md, input int per, input int dur, input string where);
    mode = md; period = 8'(per); duration = 16'(dur); start = 1'b1;
    step(where);
    start = 1'b0;
  endtask

  initial begin
    nRst = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    period = '0; duration = '0; cyc = 0;
`ifdef TONE_OSC_DUTY_EN
    duty = 8'd2;
`endif
    model_reset();
    clear_obs();
    #1;
    compare_all("reset");
    step("reset_hold");
    nRst = 1'b1;
    en   = 1'b1;
    step("idle");

    // continuous, period 3: one tick per 4 enabled cycles
    begin_note(1'b0, 3, 0, "cont_start");
    clear_obs();
    for (int i = 0; i < 40; i++) step("cont");
    check("cont_ticks", 32'(n_tick), 32'd10);
    check("cont_done",  32'(n_done), 32'd0);
    stop = 1'b1; step("cont_stop"); stop = 1'b0;

    // one-shot, period 1, duration 3
    begin_note(1'b1, 1, 3, "os3_start");
    clear_obs();
    for (int i = 0; i < 10; i++) step("os3");
    check("os3_ticks", 32'(n_tick), 32'd3);
    check("os3_done",  32'(n_done), 32'd1);
    check("os3_busy_end", 32'(busy), 32'd0);
    check("os3_wave_end", 32'(wave_out), 32'd0);

    // one-shot, zero duration
    clear_obs();
    begin_note(1'b1, 2, 0, "os0_start");
    for (int i = 0; i < 4; i++) step("os0");
    check("os0_ticks", 32'(n_tick), 32'd0);
    check("os0_done",  32'(n_done), 32'd1);
    check("os0_busy_le1", 32'(n_busy <= 1), 32'd1);

    // en held low for 5 cycles mid-note stretches one tick gap from 5 to 10
    begin_note(1'b0, 4, 0, "frz_start");
    clear_obs();
    for (int i = 0; i < 7; i++) step("frz_pre");
    en = 1'b0;
    for (int i = 0; i < 5; i++) step("frz_off");
    en = 1'b1;
    for (int i = 0; i < 20; i++) step("frz_post");
    check("frz_gap", 32'(max_gap), 32'd10);

    // simultaneous start and stop while running
    clear_obs();
    start = 1'b1; stop = 1'b1; mode = 1'b1; duration = 16'd1;
    step("ss");
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) step("ss_after");
    check("ss_nodone", 32'(n_done), 32'd0);

    // asynchronous reset mid-note
    begin_note(1'b1, 0, 50, "ar_start");
    for (int i = 0; i < 5; i++) step("ar_run");
    @(negedge clk);
    nRst = 1'b0;
    #1;
    model_reset();
    compare_all("ar_async");
    step("ar_hold");
    nRst = 1'b1;
    begin_note(1'b0, 1, 0, "ar_restart");
    for (int i = 0; i < 6; i++) step("ar_after");

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 4) != 0);
      mode     = 1'($urandom_range(0, 1));
      period   = 8'($urandom_range(0, 5));
      duration = 16'($urandom_range(0, 4));
`ifdef TONE_OSC_DUTY_EN
      duty     = 8'($urandom_range(0, 6));
`endif
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
